seq_restoring_divider: RTL
==========================

// Module: seq_restoring_divider
// PURPOSE
//  Multi-cycle unsigned restoring divider. Computes quotient and remainder by
//  repeated trial subtraction, one quotient bit per clock, MSB first.
//  Sits beside the combinational adder/subtractor in the arithmetic library.
//  It reuses the subtract path (cin=1, inverted B) as its only datapath.
// PARAMETERS
//  WIDTH  4  operand, quotient and remainder width in bits (>=2)
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst          in   1      synchronous reset, active-high
//  start        in   1      request; sampled only when busy=0
//  dividend     in   WIDTH  unsigned dividend; captured with accepted start
//  divisor      in   WIDTH  unsigned divisor; captured with accepted start
//  busy         out  1      high while a division is in progress
//  done         out  1      one-cycle pulse; results valid from this cycle
//  quotient     out  WIDTH  result; held until the next accepted start
//  remainder    out  WIDTH  result; held until the next accepted start
//  div_by_zero  out  1      set with done when captured divisor==0
// BEHAVIOUR
//  Reset: one clock, synchronous reset, active-high (rst). On rst=1 at a
//   rising edge: state=IDLE; busy, done, div_by_zero, quotient and remainder
//   all go to 0. rst overrides start in the same cycle.
//  FSM states: IDLE, RUN, FIN.
//   IDLE: if start=1, capture the operands and clear the iteration counter.
//    If divisor!=0, go to RUN. If divisor==0, go to FIN.
//   RUN: one iteration per edge. After iteration WIDTH-1, go to FIN.
//   FIN: done=1 for exactly this one cycle, then IDLE.
//    start=1 in FIN is accepted, as in IDLE, so back-to-back operation works.
//  Iteration (partial remainder P is WIDTH+1 bits, Q is a shift register):
//   Form T = {P[WIDTH-1:0], Q[WIDTH-1]}. Compute D = T - {1'b0, divisor}.
//   Compute D in the sub-module with cin=1; borrow = ~cout.
//   If borrow=0: P=D and shift a 1 into Q. Otherwise: P=T and shift a 0 in.
//   Q starts equal to dividend; P starts at 0.
//  Latency: start sampled at edge 0 -> RUN after edges 1..WIDTH -> done high
//   in the cycle after edge WIDTH+1. Divide-by-zero: done after edge 1.
//  busy=1 from the edge after the accepted start until the edge entering FIN.
//   busy=0 in FIN.
//  start while busy=1 is ignored. Operand changes while busy have no effect.
//  quotient and remainder update only on the edge entering FIN.
//   They are stable in FIN and IDLE.
//  Divide-by-zero result: quotient = all ones, remainder = dividend,
//   div_by_zero=1. Otherwise div_by_zero=0.
//  Identity that always holds when div_by_zero=0:
//   dividend == quotient*divisor + remainder, with remainder < divisor.
//  rst during RUN aborts the operation. No done pulse is produced for the
//   aborted request.
// STRUCTURE
//  Package arith_pkg: FSM state encoding (IDLE/RUN/FIN), default WIDTH,
//   counter width = $clog2(WIDTH+1).
//  Sub-module add_sub_w, parameterised WIDTH+1: a, b, cin -> sum, cout;
//   cin=1 gives a - b. Instantiated once for the trial subtraction.
//  Top level holds the FSM, counter, P/Q registers and output registers.
// TESTING
//  WIDTH=4, dividend=13, divisor=3, start 1 cycle -> done in the cycle after
//   edge 5, q=4, r=1, dz=0
//  dividend=15, divisor=1 -> q=15, r=0. dividend=7, divisor=9 -> q=0, r=7.
//  dividend=9, divisor=0 -> done in the cycle after edge 1, dz=1, q=4'b1111, r=9
//  start pulsed mid-RUN with new operands -> ignored; first result unchanged;
//   exactly one done pulse
//  start held high through FIN with 12/5 after 13/3 -> q=4, r=1, then
//   immediately busy; next done gives q=2, r=2
//  rst asserted at edge 3 of RUN -> all outputs 0 next cycle, no done;
//   a fresh start then completes normally
//  Exhaustive sweep of all 256 operand pairs vs the reference model (a/b, a%b)
//   -> zero mismatches

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-library constants: divider FSM encoding, default width,
// and the iteration counter sizing helper.
package arith_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/add_sub_w.sv
// Ripple-style adder/subtractor: cin=1 inverts b so that sum = a - b and
// cout=1 means no borrow.
module add_sub_w #(
    parameter int WIDTH = arith_pkg::DEF_WIDTH + 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff       = b ^ {WIDTH{cin}};
        {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB
// first, built around a single shared trial subtractor.
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             cout;
    logic             borrow;
    logic             accept;

    // The restored partial remainder is always < divisor, so its MSB is
    // never consumed by the next trial; it is kept only for full P width.
    logic             unused_p_msb;
    assign unused_p_msb = p_q[WIDTH];

    assign trial  = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign borrow = ~cout;

    add_sub_w #(.WIDTH(WIDTH + 1)) u_sub (
        .a    (trial),
        .b    ({1'b0, dvs_q}),
        .cin  (1'b1),
        .sum  (diff),
        .cout (cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        accept  = start && (state_q == ST_IDLE || state_q == ST_FIN);

        case (state_q)
            ST_RUN: begin
                p_d   = borrow ? trial : diff;
                q_d   = {q_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_FIN;
                    quo_d   = q_d;
                    rem_d   = p_d[WIDTH-1:0];
                    dz_d    = 1'b0;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Back-to-back: a start seen in FIN is taken just like in IDLE.
        if (accept) begin
            cnt_d = '0;
            p_d   = '0;
            q_d   = dividend;
            dvs_d = divisor;
            if (divisor == '0) begin
                state_d = ST_FIN;
                quo_d   = '1;
                rem_d   = dividend;
                dz_d    = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_FIN);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;

endmodule
